vic_ack_ctrl: RTL and testbench

VIC_ACK_CTRL -- requirements
Module: vic_ack_ctrl

---
 rtl/vic_ack_ctrl_if.sv | 38 +++
 rtl/vic_ack_ctrl.sv | 112 +++++++++++
 tb/tb_vic_ack_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vic_ack_ctrl_if.sv
// Bus bundle for the interrupt acknowledge controller. It carries the
// peripheral sources, the arbiter loop and the CPU handshake.
// The slave modport is the controller; master is the surrounding system.
interface vic_ack_ctrl_if;
  logic [15:0] irq_src;
  logic [15:0] irq_edge;
  logic [15:0] irq_enable;
  logic        nv_irq_src;
  logic [15:0] v_pending;
  logic        nv_pending;
  logic        arb_request;
  logic        arb_is_nv;
  logic [3:0]  arb_handler_num;
  logic        cpu_irq;
  logic        cpu_ack;
  logic [3:0]  cpu_vector;
  logic        cpu_vector_nv;
  logic        cpu_vector_valid;
  logic        cpu_eoi;
  logic [15:0] in_service;
  logic        busy;

  modport slave (
    input  irq_src, irq_edge, irq_enable, nv_irq_src,
    input  arb_request, arb_is_nv, arb_handler_num,
    input  cpu_ack, cpu_eoi,
    output v_pending, nv_pending, cpu_irq, cpu_vector, cpu_vector_nv,
    output cpu_vector_valid, in_service, busy
  );

  modport master (
    output irq_src, irq_edge, irq_enable, nv_irq_src,
    output arb_request, arb_is_nv, arb_handler_num,
    output cpu_ack, cpu_eoi,
    input  v_pending, nv_pending, cpu_irq, cpu_vector, cpu_vector_nv,
    input  cpu_vector_valid, in_service, busy
  );
endinterface

// File: rtl/vic_ack_ctrl.sv
// Vectored interrupt acknowledge controller: collects edge/level pending
// state for 16 vectored sources plus one non-vectored source, presents it
// to an external arbiter, and runs the CPU irq/ack/vector/eoi handshake.
// A single interrupt is serviced at a time (no nesting).
module vic_ack_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  vic_ack_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, VEC, SERVICE} state_e;

  // Counter value seen on the last REQ cycle before giving up.
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] src_q;
  logic [15:0] epend_q, epend_d;
  logic [15:0] pending;
  logic [15:0] ack_clr;
  logic        nv_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  vec_q, vec_d;
  logic        vec_nv_q, vec_nv_d;
  logic [15:0] insvc_q, insvc_d;

  // Level sources follow the sampled input; edge sources use the sticky bit.
  assign pending        = (bus.irq_edge & epend_q) | (~bus.irq_edge & src_q);
  assign bus.v_pending  = pending & bus.irq_enable;
  assign bus.nv_pending = nv_q;

  assign bus.cpu_irq          = (state_q == REQ);
  assign bus.cpu_vector_valid = (state_q == VEC);
  assign bus.busy             = (state_q == VEC) || (state_q == SERVICE);
  assign bus.cpu_vector       = vec_q;
  assign bus.cpu_vector_nv    = vec_nv_q;
  assign bus.in_service       = insvc_q;

  // Edge pending: a new edge sets, an ack of that source clears; the set
  // wins so an edge landing in the ack cycle is never lost.
  always_comb begin
    epend_d = (epend_q & ~ack_clr) | (bus.irq_src & ~src_q & bus.irq_edge);
  end

  // Handshake sequencing: request, capture vector on ack, service until eoi.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    vec_nv_d = vec_nv_q;
    insvc_d  = insvc_q;
    ack_clr  = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.arb_request) begin
          state_d = REQ;
          cnt_d   = '0;
        end
      end
      REQ: begin
        // Ack beats both request withdrawal and timeout.
        if (bus.cpu_ack) begin
          vec_d    = bus.arb_handler_num;
          vec_nv_d = bus.arb_is_nv;
          if (bus.arb_is_nv) begin
            insvc_d = '0;
          end else begin
            ack_clr = 16'(1) << bus.arb_handler_num;
            insvc_d = 16'(1) << bus.arb_handler_num;
          end
          state_d = VEC;
        end else if (!bus.arb_request || cnt_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      VEC: state_d = SERVICE;
      SERVICE: begin
        if (bus.cpu_eoi) begin
          insvc_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      src_q    <= '0;
      epend_q  <= '0;
      nv_q     <= 1'b0;
      cnt_q    <= '0;
      vec_q    <= '0;
      vec_nv_q <= 1'b0;
      insvc_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= bus.irq_src;
      epend_q  <= epend_d;
      nv_q     <= bus.nv_irq_src;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      vec_nv_q <= vec_nv_d;
      insvc_q  <= insvc_d;
    end
  end
endmodule

// File: tb/tb_vic_ack_ctrl.sv
// Bench for vic_ack_ctrl: directed handshake scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_vic_ack_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  vic_ack_ctrl_if bus();
  vic_ack_ctrl #(.ACK_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  // Arbiter stand-in: non-vectored beats vectored, lowest index wins.
  always_comb begin
    bus.arb_request     = (|bus.v_pending) | bus.nv_pending;
    bus.arb_is_nv       = bus.nv_pending;
    bus.arb_handler_num = lowest(bus.v_pending);
  end

  // ---------------- behavioural model ----------------
  logic [15:0] m_src, m_epend, m_insvc;
  logic        m_nv, m_vld, m_svc, m_vnv;
  logic [3:0]  m_vec;
  int          m_age;  // cycles spent requesting, -1 when not requesting

  task automatic model_reset();
    m_src = '0; m_epend = '0; m_insvc = '0;
    m_nv = 1'b0; m_vld = 1'b0; m_svc = 1'b0; m_vnv = 1'b0;
    m_vec = '0; m_age = -1;
  endtask

  function automatic logic [15:0] m_vpend();
    return ((bus.irq_edge & m_epend) | (~bus.irq_edge & m_src)) & bus.irq_enable;
  endfunction

  task automatic model_step();
    logic [15:0] vp;
    logic        areq, acked;
    logic [3:0]  w;
    if (rst) begin
      model_reset();
      return;
    end
    vp = m_vpend(); areq = (|vp) | m_nv; w = lowest(vp); acked = 1'b0;
    if (m_vld) begin
      m_vld = 1'b0; m_svc = 1'b1;
    end else if (m_svc) begin
      if (bus.cpu_eoi) begin m_svc = 1'b0; m_insvc = '0; end
    end else if (m_age >= 0) begin
      if (bus.cpu_ack) begin
        m_vec = w; m_vnv = m_nv; m_vld = 1'b1; m_age = -1; acked = 1'b1;
        m_insvc = '0;
        if (!m_nv) m_insvc[w] = 1'b1;
      end else if (!areq || m_age + 1 == TO) begin
        m_age = -1;
      end else begin
        m_age++;
      end
    end else if (areq) begin
      m_age = 0;
    end
    if (acked && !m_nv) m_epend[w] = 1'b0;
    m_epend = m_epend | (bus.irq_src & ~m_src & bus.irq_edge);
    m_src = bus.irq_src;
    m_nv  = bus.nv_irq_src;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.irq_src = '0; bus.irq_edge = '0; bus.irq_enable = '0;
    bus.nv_irq_src = 1'b0; bus.cpu_ack = 1'b0; bus.cpu_eoi = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    logic [40:0] o;
    rst = 1'b1;
    bus.irq_src = 16'h0001; bus.irq_edge = 16'h0001; bus.irq_enable = 16'h0001;
    tick(); tick();
    o = {bus.cpu_irq, bus.cpu_vector, bus.cpu_vector_nv, bus.cpu_vector_valid,
         bus.v_pending, bus.nv_pending, bus.in_service, bus.busy};
    tests++;
    if (o !== 41'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", o); end
    rst = 1'b0;
    tick();
    tests++;
    if (bus.v_pending !== 16'h0001 || bus.cpu_irq !== 1'b0) begin
      fails++; $display("FAIL reset_release_edge: vp=%h irq=%b want 0001 0", bus.v_pending, bus.cpu_irq);
    end
    tick();
    tests++;
    if (bus.cpu_irq !== 1'b1) begin fails++; $display("FAIL reset_release_req: irq=%b want 1", bus.cpu_irq); end
  endtask

  task automatic test_edge_basic();
    do_reset();
    bus.irq_edge = 16'h0008; bus.irq_enable = 16'h0008; bus.irq_src = 16'h0008;
    tick();
    bus.irq_src = '0;
    tests++;
    if (bus.v_pending !== 16'h0008 || bus.cpu_irq !== 1'b0) begin
      fails++; $display("FAIL edge_sample: vp=%h irq=%b want 0008 0", bus.v_pending, bus.cpu_irq);
    end
    tick();
    tests++;
    if (bus.cpu_irq !== 1'b1) begin fails++; $display("FAIL edge_irq: irq=%b want 1", bus.cpu_irq); end
    bus.cpu_ack = 1'b1; tick(); bus.cpu_ack = 1'b0;
    tests++;
    if (bus.cpu_vector !== 4'd3 || bus.cpu_vector_valid !== 1'b1 || bus.in_service !== 16'h0008 ||
        bus.v_pending !== 16'h0000 || bus.busy !== 1'b1 || bus.cpu_irq !== 1'b0) begin
      fails++; $display("FAIL edge_ack: vec=%0d vld=%b isv=%h vp=%h busy=%b irq=%b want 3 1 0008 0000 1 0",
        bus.cpu_vector, bus.cpu_vector_valid, bus.in_service, bus.v_pending, bus.busy, bus.cpu_irq);
    end
    tick();
    tests++;
    if (bus.cpu_vector_valid !== 1'b0 || bus.busy !== 1'b1 || bus.cpu_vector !== 4'd3) begin
      fails++; $display("FAIL edge_strobe_len: vld=%b busy=%b vec=%0d want 0 1 3",
        bus.cpu_vector_valid, bus.busy, bus.cpu_vector);
    end
    bus.cpu_ack = 1'b1; tick(); bus.cpu_ack = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.cpu_vector_valid !== 1'b0 || bus.in_service !== 16'h0008) begin
      fails++; $display("FAIL ack_in_service_ignored: busy=%b vld=%b isv=%h want 1 0 0008",
        bus.busy, bus.cpu_vector_valid, bus.in_service);
    end
    bus.cpu_eoi = 1'b1; tick(); bus.cpu_eoi = 1'b0;
    tests++;
    if (bus.in_service !== 16'h0 || bus.busy !== 1'b0 || bus.cpu_vector !== 4'd3 || bus.cpu_irq !== 1'b0) begin
      fails++; $display("FAIL edge_eoi: isv=%h busy=%b vec=%0d irq=%b want 0000 0 3 0",
        bus.in_service, bus.busy, bus.cpu_vector, bus.cpu_irq);
    end
  endtask

  task automatic test_edge_collision();
    do_reset();
    bus.irq_edge = 16'h0020; bus.irq_enable = 16'h0020; bus.irq_src = 16'h0020;
    tick();
    bus.irq_src = '0;
    tick();
    bus.cpu_ack = 1'b1; bus.irq_src = 16'h0020;
    tick();
    bus.cpu_ack = 1'b0; bus.irq_src = '0;
    tests++;
    if (bus.v_pending !== 16'h0020 || bus.in_service !== 16'h0020 || bus.cpu_vector !== 4'd5) begin
      fails++; $display("FAIL collide_keep: vp=%h isv=%h vec=%0d want 0020 0020 5",
        bus.v_pending, bus.in_service, bus.cpu_vector);
    end
    tick(); tick();
    tests++;
    if (bus.cpu_irq !== 1'b0) begin fails++; $display("FAIL no_nesting: irq=%b want 0", bus.cpu_irq); end
    bus.cpu_eoi = 1'b1; tick(); bus.cpu_eoi = 1'b0;
    tick();
    tests++;
    if (bus.cpu_irq !== 1'b1) begin fails++; $display("FAIL collide_rereq: irq=%b want 1", bus.cpu_irq); end
    bus.cpu_ack = 1'b1; tick(); bus.cpu_ack = 1'b0;
    tests++;
    if (bus.cpu_vector !== 4'd5 || bus.v_pending !== 16'h0) begin
      fails++; $display("FAIL collide_second_ack: vec=%0d vp=%h want 5 0000", bus.cpu_vector, bus.v_pending);
    end
  endtask

  task automatic test_level();
    do_reset();
    bus.irq_edge = 16'h0000; bus.irq_enable = 16'h0080; bus.irq_src = 16'h0080;
    tick();
    tests++;
    if (bus.v_pending !== 16'h0080) begin fails++; $display("FAIL level_pend: vp=%h want 0080", bus.v_pending); end
    tick();
    bus.cpu_ack = 1'b1; tick(); bus.cpu_ack = 1'b0;
    tests++;
    if (bus.cpu_vector !== 4'd7 || bus.v_pending !== 16'h0080) begin
      fails++; $display("FAIL level_ack: vec=%0d vp=%h want 7 0080", bus.cpu_vector, bus.v_pending);
    end
    tick();
    bus.cpu_eoi = 1'b1; tick(); bus.cpu_eoi = 1'b0;
    tick();
    tests++;
    if (bus.cpu_irq !== 1'b1) begin fails++; $display("FAIL level_rereq: irq=%b want 1", bus.cpu_irq); end
    bus.cpu_ack = 1'b1; tick(); bus.cpu_ack = 1'b0;
    tests++;
    if (bus.cpu_vector !== 4'd7 || bus.cpu_vector_valid !== 1'b1) begin
      fails++; $display("FAIL level_second_ack: vec=%0d vld=%b want 7 1", bus.cpu_vector, bus.cpu_vector_valid);
    end
    bus.irq_src = '0;
  endtask

  task automatic test_timeout();
    logic [5:0] seq;
    do_reset();
    bus.irq_edge = 16'h0004; bus.irq_enable = 16'h0004; bus.irq_src = 16'h0004;
    tick();
    bus.irq_src = '0;
    tick();
    seq = {5'd0, bus.cpu_irq};
    for (int i = 0; i < 5; i++) begin
      tick();
      seq = {seq[4:0], bus.cpu_irq};
    end
    tests++;
    if (seq !== 6'b111101) begin fails++; $display("FAIL timeout_shape: irq seq=%b want 111101", seq); end
    tests++;
    if (bus.v_pending !== 16'h0004) begin fails++; $display("FAIL timeout_pend: vp=%h want 0004", bus.v_pending); end
  endtask

  task automatic test_nv();
    do_reset();
    bus.nv_irq_src = 1'b1;
    tick();
    tests++;
    if (bus.nv_pending !== 1'b1 || bus.v_pending !== 16'h0) begin
      fails++; $display("FAIL nv_pend: nvp=%b vp=%h want 1 0000", bus.nv_pending, bus.v_pending);
    end
    tick();
    bus.cpu_ack = 1'b1; bus.nv_irq_src = 1'b0; tick(); bus.cpu_ack = 1'b0;
    tests++;
    if (bus.cpu_vector_nv !== 1'b1 || bus.in_service !== 16'h0 || bus.busy !== 1'b1 || bus.cpu_vector_valid !== 1'b1) begin
      fails++; $display("FAIL nv_ack: vnv=%b isv=%h busy=%b vld=%b want 1 0000 1 1",
        bus.cpu_vector_nv, bus.in_service, bus.busy, bus.cpu_vector_valid);
    end
    tick(); tick();
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL nv_busy_hold: busy=%b want 1", bus.busy); end
    bus.cpu_eoi = 1'b1; tick(); bus.cpu_eoi = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.cpu_vector_nv !== 1'b1) begin
      fails++; $display("FAIL nv_eoi: busy=%b vnv=%b want 0 1", bus.busy, bus.cpu_vector_nv);
    end
  endtask

  task automatic test_reset_in_service();
    logic [40:0] o;
    do_reset();
    bus.irq_edge = 16'h0002; bus.irq_enable = 16'h0002; bus.irq_src = 16'h0002;
    tick();
    bus.irq_src = '0;
    tick();
    bus.cpu_ack = 1'b1; tick(); bus.cpu_ack = 1'b0;
    tick();
    tests++;
    if (bus.busy !== 1'b1 || bus.in_service !== 16'h0002) begin
      fails++; $display("FAIL svc_entry: busy=%b isv=%h want 1 0002", bus.busy, bus.in_service);
    end
    rst = 1'b1;
    #1;
    o = {bus.cpu_irq, bus.cpu_vector, bus.cpu_vector_nv, bus.cpu_vector_valid,
         bus.v_pending, bus.nv_pending, bus.in_service, bus.busy};
    tests++;
    if (o !== 41'd0) begin fails++; $display("FAIL async_reset_outputs: got %h want 0", o); end
    model_reset();
    #1;
    rst = 1'b0;
    tick();
    bus.cpu_eoi = 1'b1; tick(); bus.cpu_eoi = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.in_service !== 16'h0 || bus.cpu_irq !== 1'b0 || bus.cpu_vector_valid !== 1'b0) begin
      fails++; $display("FAIL stale_eoi: busy=%b isv=%h irq=%b vld=%b want 0 0000 0 0",
        bus.busy, bus.in_service, bus.cpu_irq, bus.cpu_vector_valid);
    end
  endtask

  task automatic test_random(input int cycles);
    logic [40:0] got, exp;
    do_reset();
    bus.irq_edge   = 16'($urandom);
    bus.irq_enable = 16'($urandom);
    for (int c = 0; c < cycles; c++) begin
      bus.irq_src = bus.irq_src ^ 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) bus.irq_enable = 16'($urandom);
      if (bus.nv_irq_src) bus.nv_irq_src = ($urandom_range(0, 2) != 0);
      else                bus.nv_irq_src = ($urandom_range(0, 39) == 0);
      bus.cpu_ack = ($urandom_range(0, 2) == 0);
      bus.cpu_eoi = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      got = {bus.cpu_irq, bus.cpu_vector, bus.cpu_vector_nv, bus.cpu_vector_valid,
             bus.v_pending, bus.nv_pending, bus.in_service, bus.busy};
      exp = {(m_age >= 0), m_vec, m_vnv, m_vld, m_vpend(), m_nv, m_insvc, (m_vld | m_svc)};
      tests++;
      if (got !== exp) begin
        fails++; $display("FAIL random_cycle %0d: got %h want %h", c, got, exp);
      end
    end
    rst = 1'b0; bus.cpu_ack = 1'b0; bus.cpu_eoi = 1'b0;
  endtask

  initial begin
    bus.irq_src = '0; bus.irq_edge = '0; bus.irq_enable = '0;
    bus.nv_irq_src = 1'b0; bus.cpu_ack = 1'b0; bus.cpu_eoi = 1'b0;
    model_reset();
    test_reset();
    test_edge_basic();
    test_edge_collision();
    test_level();
    test_timeout();
    test_nv();
    test_reset_in_service();
    test_random(1500);
    test_random(1500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
